// File: rtl/regmap_arbiter.sv
// Round-robin arbiter serialising two single-beat requesters onto one register-map port.
// Optional REGMAP_ARB_TIMEOUT_EN: ACCESS waits for i_rdvalid with a TIMEOUT-cycle bound and flags o_err.
module regmap_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_wren0,
  input  logic                  i_wren1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wrdata0,
  input  logic [DATA_WIDTH-1:0] i_wrdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rddata0,
  output logic [DATA_WIDTH-1:0] o_rddata1,
  output logic                  o_wren,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wrdata,
  input  logic                  i_rdvalid,
  input  logic [DATA_WIDTH-1:0] i_rddata,
  output logic                  o_busy,
  output logic                  o_gnt,
  output logic                  o_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q;
  logic                  last_gnt_q;
  logic                  gnt_q;
  logic                  wren_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wrdata_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rddata0_q;
  logic [DATA_WIDTH-1:0] rddata1_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  tout_q;

  logic win_d;
  logic acc_done_d;
  logic tout_d;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    win_d = i_req1;
    if (i_req0 && i_req1) win_d = ~last_gnt_q;
  end

`ifdef REGMAP_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;

  // Valid data takes priority over a timeout landing on the same cycle.
  always_comb begin
    acc_done_d = i_rdvalid || (cnt_q == TO_LAST);
    tout_d     = ~i_rdvalid;
  end
`else
  logic unused_rdvalid;
  assign unused_rdvalid = i_rdvalid ^ (TIMEOUT == 0);

  always_comb begin
    acc_done_d = 1'b1;
    tout_d     = 1'b0;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rddata0_q  <= '0;
      rddata1_q  <= '0;
      cap_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tout_q     <= 1'b0;
`ifdef REGMAP_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req0 || i_req1) begin
            gnt_q      <= win_d;
            last_gnt_q <= win_d;
            wren_q     <= win_d ? i_wren1   : i_wren0;
            addr_q     <= win_d ? i_addr1   : i_addr0;
            wrdata_q   <= win_d ? i_wrdata1 : i_wrdata0;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
`ifdef REGMAP_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        ACCESS: begin
          if (acc_done_d) begin
            cap_q   <= tout_d ? '0 : i_rddata;
            tout_q  <= tout_d;
            state_q <= RESP;
          end
`ifdef REGMAP_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        RESP: begin
          if (gnt_q) begin
            ack1_q    <= 1'b1;
            rddata1_q <= cap_q;
          end else begin
            ack0_q    <= 1'b1;
            rddata0_q <= cap_q;
          end
          err_q   <= tout_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ack0    = ack0_q;
  assign o_ack1    = ack1_q;
  assign o_rddata0 = rddata0_q;
  assign o_rddata1 = rddata1_q;
  assign o_wren    = wren_q;
  assign o_addr    = addr_q;
  assign o_wrdata  = wrdata_q;
  assign o_busy    = busy_q;
  assign o_gnt     = gnt_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_regmap_arbiter.sv
// Directed bench for regmap_arbiter with a 16-entry register-map model.
// Timeout scenarios are exercised only when REGMAP_ARB_TIMEOUT_EN is defined.
module tb_regmap_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req0, i_req1, i_wren0, i_wren1;
  logic [3:0] i_addr0, i_addr1;
  logic [7:0] i_wrdata0, i_wrdata1;
  logic       o_ack0, o_ack1;
  logic [7:0] o_rddata0, o_rddata1;
  logic       o_wren;
  logic [3:0] o_addr;
  logic [7:0] o_wrdata;
  logic       i_rdvalid;
  logic [7:0] i_rddata;
  logic       o_busy, o_gnt, o_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [16];
  logic       load;
  int         acc_cnt;
  int         rdv_delay;

  always #5 i_clk = ~i_clk;

  regmap_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_wren0(i_wren0), .i_wren1(i_wren1),
    .i_addr0(i_addr0), .i_addr1(i_addr1),
    .i_wrdata0(i_wrdata0), .i_wrdata1(i_wrdata1),
    .o_ack0(o_ack0), .o_ack1(o_ack1),
    .o_rddata0(o_rddata0), .o_rddata1(o_rddata1),
    .o_wren(o_wren), .o_addr(o_addr), .o_wrdata(o_wrdata),
    .i_rdvalid(i_rdvalid), .i_rddata(i_rddata),
    .o_busy(o_busy), .o_gnt(o_gnt), .o_err(o_err)
  );

  // Register-map model: asynchronous read, synchronous write.
  assign i_rddata = mem[o_addr];
  always @(posedge i_clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      mem[0] <= 8'hA5;
    end else if (o_wren) begin
      mem[o_addr] <= o_wrdata;
    end
  end

  // rdvalid asserts once rdv_delay ACCESS cycles have gone by (0 = immediately).
  always @(posedge i_clk) acc_cnt <= o_busy ? acc_cnt + 1 : 0;
  assign i_rdvalid = (acc_cnt >= rdv_delay);

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0;
    i_req0 = 1'b0; i_req1 = 1'b0;
    tick; tick;
    i_rst_n = 1'b1;
  endtask

  task automatic run_txn(input bit who, input bit wr, input logic [3:0] a, input logic [7:0] d,
                         output int lat, output int wcnt, output logic [3:0] wa,
                         output logic [7:0] wd, output bit oth);
    if (who) begin
      i_req1 = 1'b1; i_wren1 = wr; i_addr1 = a; i_wrdata1 = d;
    end else begin
      i_req0 = 1'b1; i_wren0 = wr; i_addr0 = a; i_wrdata0 = d;
    end
    lat = 0; wcnt = 0; wa = '0; wd = '0; oth = 1'b0;
    do begin
      tick;
      lat++;
      if (o_wren) begin wcnt++; wa = o_addr; wd = o_wrdata; end
      if (who ? o_ack0 : o_ack1) oth = 1'b1;
    end while (!(who ? o_ack1 : o_ack0) && lat < 40);
    if (who) i_req1 = 1'b0; else i_req0 = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if ({o_ack0, o_ack1, o_rddata0, o_rddata1, o_wren, o_addr, o_wrdata, o_busy, o_gnt, o_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%b%b rd0=%h rd1=%h wren=%b addr=%h wd=%h busy=%b gnt=%b err=%b, want all 0",
               o_ack0, o_ack1, o_rddata0, o_rddata1, o_wren, o_addr, o_wrdata, o_busy, o_gnt, o_err);
    end
  endtask

  task automatic test_read;
    int lat, wcnt; logic [3:0] wa; logic [7:0] wd; bit oth;
    run_txn(1'b0, 1'b0, 4'h0, 8'h00, lat, wcnt, wa, wd, oth);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL read_latency: got %0d want 3", lat); end
    n_cmp++; if (o_rddata0 !== 8'hA5) begin n_bad++; $display("FAIL read_data0: got %h want a5", o_rddata0); end
    n_cmp++; if (oth !== 1'b0) begin n_bad++; $display("FAIL read_no_ack1: got %b want 0", oth); end
    n_cmp++; if (wcnt !== 0) begin n_bad++; $display("FAIL read_no_wren: got %0d pulses want 0", wcnt); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", o_err); end
    tick;
    n_cmp++; if (o_ack0 !== 1'b0) begin n_bad++; $display("FAIL ack0_one_cycle: got %b want 0", o_ack0); end
  endtask

  task automatic test_write;
    int lat, wcnt; logic [3:0] wa; logic [7:0] wd; bit oth;
    run_txn(1'b1, 1'b1, 4'h2, 8'h3C, lat, wcnt, wa, wd, oth);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d want 3", lat); end
    n_cmp++; if (wcnt !== 1) begin n_bad++; $display("FAIL write_wren_pulses: got %0d want 1", wcnt); end
    n_cmp++; if ({wa, wd} !== {4'h2, 8'h3C}) begin n_bad++; $display("FAIL write_bus: got addr=%h data=%h want 2/3c", wa, wd); end
    n_cmp++; if (o_rddata1 !== 8'h12) begin n_bad++; $display("FAIL write_prewrite_data: got %h want 12", o_rddata1); end
    n_cmp++; if (oth !== 1'b0) begin n_bad++; $display("FAIL write_no_ack0: got %b want 0", oth); end
    tick;
    run_txn(1'b0, 1'b0, 4'h2, 8'h00, lat, wcnt, wa, wd, oth);
    n_cmp++; if (o_rddata0 !== 8'h3C) begin n_bad++; $display("FAIL readback: got %h want 3c", o_rddata0); end
    n_cmp++; if (o_rddata1 !== 8'h12) begin n_bad++; $display("FAIL rddata1_held: got %h want 12", o_rddata1); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] seq;
    logic [5:0] exp_seq;
    int k, t, last_t, gap_bad;
    exp_seq = 6'b101010;
    seq = '0; k = 0; t = 0; last_t = 0; gap_bad = 0;
    do_reset;
    i_req0 = 1'b1; i_wren0 = 1'b0; i_addr0 = 4'h0;
    i_req1 = 1'b1; i_wren1 = 1'b0; i_addr1 = 4'h2;
    tick; t++;
    n_cmp++; if (o_gnt !== 1'b0) begin n_bad++; $display("FAIL tie_first_gnt: got %b want 0", o_gnt); end
    while (k < 6 && t < 60) begin
      tick; t++;
      if (o_ack0 || o_ack1) begin
        seq[k] = o_ack1;
        if (k > 0 && (t - last_t) != 3) gap_bad++;
        last_t = t;
        k++;
      end
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    n_cmp++; if (k !== 6) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 6", k); end
    n_cmp++; if (seq !== exp_seq) begin n_bad++; $display("FAIL b2b_order: got %b want %b (bit0 first)", seq, exp_seq); end
    n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL b2b_spacing: got %0d gaps not 3 want 0", gap_bad); end
    n_cmp++; if ({o_rddata0, o_rddata1} !== {8'hA5, 8'h3C}) begin n_bad++; $display("FAIL b2b_data: got %h/%h want a5/3c", o_rddata0, o_rddata1); end
    tick;
  endtask

  task automatic test_reset_mid;
    int acks, t;
    do_reset;
    i_req1 = 1'b1; i_wren1 = 1'b1; i_addr1 = 4'h5; i_wrdata1 = 8'h77;
    tick;
    n_cmp++; if ({o_busy, o_wren} !== 2'b11) begin n_bad++; $display("FAIL mid_access: got busy=%b wren=%b want 1/1", o_busy, o_wren); end
    i_rst_n = 1'b0; i_req1 = 1'b0;
    tick;
    n_cmp++;
    if ({o_ack0, o_ack1, o_rddata0, o_rddata1, o_wren, o_addr, o_wrdata, o_busy, o_gnt, o_err} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got ack=%b%b rd0=%h rd1=%h wren=%b addr=%h wd=%h busy=%b gnt=%b err=%b, want all 0",
               o_ack0, o_ack1, o_rddata0, o_rddata1, o_wren, o_addr, o_wrdata, o_busy, o_gnt, o_err);
    end
    i_rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (o_ack0 || o_ack1) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL mid_no_ack: got %0d acks want 0", acks); end
    i_req0 = 1'b1; i_wren0 = 1'b0; i_addr0 = 4'h0;
    i_req1 = 1'b1; i_wren1 = 1'b0; i_addr1 = 4'h2;
    tick;
    n_cmp++; if (o_gnt !== 1'b0) begin n_bad++; $display("FAIL post_reset_tie_gnt: got %b want 0", o_gnt); end
    t = 0;
    while (!(o_ack0 || o_ack1) && t < 20) begin tick; t++; end
    i_req0 = 1'b0; i_req1 = 1'b0;
    n_cmp++; if ({o_ack0, o_ack1} !== 2'b10) begin n_bad++; $display("FAIL post_reset_first_ack: got ack0=%b ack1=%b want 1/0", o_ack0, o_ack1); end
    tick;
  endtask

`ifdef REGMAP_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int lat, wcnt; logic [3:0] wa; logic [7:0] wd; bit oth;
    do_reset;
    rdv_delay = 1000;
    run_txn(1'b0, 1'b0, 4'h0, 8'h00, lat, wcnt, wa, wd, oth);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL timeout_latency: got %0d want 17", lat); end
    n_cmp++; if ({o_ack0, o_err} !== 2'b11) begin n_bad++; $display("FAIL timeout_err: got ack0=%b err=%b want 1/1", o_ack0, o_err); end
    n_cmp++; if (o_rddata0 !== 8'h00) begin n_bad++; $display("FAIL timeout_data: got %h want 00", o_rddata0); end
    tick;
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_pulse: got %b want 0", o_err); end
    rdv_delay = 4;
    run_txn(1'b0, 1'b0, 4'h0, 8'h00, lat, wcnt, wa, wd, oth);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL late_valid_latency: got %0d want 7", lat); end
    n_cmp++; if ({o_err, o_rddata0} !== {1'b0, 8'hA5}) begin n_bad++; $display("FAIL late_valid_data: got err=%b data=%h want 0/a5", o_err, o_rddata0); end
    rdv_delay = 0;
    tick;
  endtask
`endif

  initial begin
    i_rst_n = 1'b0;
    i_req0 = 1'b0; i_req1 = 1'b0; i_wren0 = 1'b0; i_wren1 = 1'b0;
    i_addr0 = '0; i_addr1 = '0; i_wrdata0 = '0; i_wrdata1 = '0;
    rdv_delay = 0;
    load = 1'b1;
    tick;
    load = 1'b0;
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_reset_mid;
`ifdef REGMAP_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
